data_mem_responder: RTL and testbench

Multi-cycle data-memory responder that services load/store requests from the CPU's memory stage over a valid/ready request channel and a valid/ready response channel. Supports 64-bit doubleword (LDUR/STUR) and byte (LDURB/STURB) accesses with a fixed, parameterized access latency. It replaces the zero-latency data array so the datapath can be exercised against a memory that stalls.

---
 rtl/data_mem_responder.sv | 146 ++++++++++++++
 tb/tb_data_mem_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Fixed-latency byte/doubleword data memory behind valid/ready
//            request and response channels.
// Revision : 1.0
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);
    localparam int          AW         = $clog2(DEPTH_BYTES);
    localparam logic [63:0] c_LIM_BYTE = 64'(DEPTH_BYTES - 1);
    localparam logic [63:0] c_LIM_DW   = 64'(DEPTH_BYTES - 8);
    localparam logic [3:0]  c_CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [3:0]    r_cnt;
    logic          r_write;
    logic          r_byte;
    logic [63:0]   r_addr;
    logic [63:0]   r_wdata;
    logic [63:0]   r_rdata;
    logic          r_err;
    logic [7:0]    r_mem [DEPTH_BYTES];

    logic          w_accept;
    logic          w_enter_resp;
    logic          w_op_write;
    logic          w_op_byte;
    logic [63:0]   w_op_addr;
    logic [63:0]   w_op_wdata;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic [63:0]   w_load_data;

    assign w_accept     = (r_state == c_IDLE) && req_valid;
    assign w_enter_resp = ((r_state == c_IDLE) && w_accept && (LATENCY == 1)) ||
                          ((r_state == c_WAIT) && (r_cnt == 4'd1));

    // With single-cycle latency the commit edge is the accept edge, so the live request is used.
    assign w_op_write = (r_state == c_IDLE) ? req_write : r_write;
    assign w_op_byte  = (r_state == c_IDLE) ? req_byte  : r_byte;
    assign w_op_addr  = (r_state == c_IDLE) ? req_addr  : r_addr;
    assign w_op_wdata = (r_state == c_IDLE) ? req_wdata : r_wdata;

    assign w_err = (!w_op_byte && (w_op_addr[2:0] != 3'b000)) ||
                   (w_op_addr > (w_op_byte ? c_LIM_BYTE : c_LIM_DW));
    assign w_idx = w_op_addr[AW-1:0];

    always_comb begin
        w_load_data = 64'b0;
        if (w_op_byte) begin
            w_load_data[7:0] = r_mem[w_idx];
        end else begin
            for (int i = 0; i < 8; i++) begin
                w_load_data[8*i +: 8] = r_mem[w_idx + AW'(i)];
            end
        end
    end

    // Storage is deliberately outside reset; a reset on the commit edge still suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && w_enter_resp && w_op_write && !w_err) begin
            if (w_op_byte) begin
                r_mem[w_idx] <= w_op_wdata[7:0];
            end else begin
                for (int i = 0; i < 8; i++) begin
                    r_mem[w_idx + AW'(i)] <= w_op_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (w_accept) w_state_nxt = (LATENCY == 1) ? c_RESP : c_WAIT;
            c_WAIT: if (r_cnt == 4'd1) w_state_nxt = c_RESP;
            c_RESP: if (resp_ready) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == c_IDLE);
        resp_valid = (r_state == c_RESP);
        busy       = (r_state != c_IDLE);
        resp_rdata = r_rdata;
        resp_err   = r_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_byte  <= 1'b0;
            r_addr  <= 64'b0;
            r_wdata <= 64'b0;
            r_rdata <= 64'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_byte  <= req_byte;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= c_CNT_INIT;
            end else if (r_state == c_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_err   <= w_err;
                r_rdata <= (w_op_write || w_err) ? 64'b0 : w_load_data;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Scoreboard bench for data_mem_responder against a byte-array model.
// Revision : 1.0
// ============================================================================
module tb_data_mem_responder;
    localparam int DEPTH = 1024;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic        req_byte = 1'b0;
    logic [63:0] req_addr = 64'b0;
    logic [63:0] req_wdata = 64'b0;
    logic        resp_ready = 1'b0;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_err;
    logic        busy;
    logic [63:0] resp_rdata;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur;
    logic [7:0] mdl [DEPTH];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         bp_stall = -1;
    int         stall_left = 0;
    bit         in_resp = 1'b0;
    bit         chk_idle = 1'b0;

    data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_byte   (req_byte),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A request is illegal if any byte it covers lies outside storage, or a doubleword is unaligned.
    function automatic bit mdl_err(input bit byt, input logic [63:0] a);
        if (a >= 64'(DEPTH)) return 1'b1;
        if (!byt) begin
            if (a % 8 != 0) return 1'b1;
            if (a + 8 > 64'(DEPTH)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic issue(input bit wr, input bit byt, input logic [63:0] a,
                         input logic [63:0] wd, output int acc);
        int guard;
        guard = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_byte  = byt;
        req_addr  = a;
        req_wdata = wd;
        while (!req_ready && guard <= 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard > 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL req_ready_timeout: got 0 expected 1 within 200 cycles");
        end
        acc = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_byte  = 1'($urandom);
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
    endtask

    task automatic do_req(input bit wr, input bit byt, input logic [63:0] a, input logic [63:0] wd);
        exp_t e;
        int   acc;
        int   base;
        e.rdata = 64'b0;
        e.err   = mdl_err(byt, a);
        if (!e.err) begin
            base = int'(a);
            if (wr) begin
                if (byt) mdl[base] = wd[7:0];
                else for (int i = 0; i < 8; i++) mdl[base + i] = wd[8*i +: 8];
            end else if (byt) begin
                e.rdata = {56'b0, mdl[base]};
            end else begin
                for (int i = 0; i < 8; i++) e.rdata = e.rdata | (64'(mdl[base + i]) << (8 * i));
            end
        end
        issue(wr, byt, a, wd, acc);
        e.acc = acc;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((sb.size() != 0 || in_resp) && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    // Monitor: pops one expectation per response and holds it while the response is stalled.
    always @(negedge clk) begin
        if (reset) begin
            in_resp  = 1'b0;
            chk_idle = 1'b0;
        end else if (resp_valid) begin
            chk_idle = 1'b0;
            if (!in_resp) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got rdata %h err %b expected no response",
                             resp_rdata, resp_err);
                    cur.rdata = 64'b0;
                    cur.err   = 1'b0;
                end else begin
                    cur = sb.pop_front();
                    chk("latency", 64'(cyc - cur.acc), 64'(LAT));
                end
                in_resp    = 1'b1;
                stall_left = (bp_stall >= 0) ? bp_stall : int'($urandom_range(0, 2));
            end
            chk("rdata", resp_rdata, cur.rdata);
            chk("err", 64'(resp_err), 64'(cur.err));
            chk("req_ready_in_resp", 64'(req_ready), 64'd0);
            chk("busy_in_resp", 64'(busy), 64'd1);
            if (stall_left > 0) begin
                stall_left--;
                resp_ready = 1'b0;
            end else begin
                resp_ready = 1'b1;
                in_resp    = 1'b0;
                chk_idle   = 1'b1;
            end
        end else begin
            if (chk_idle) begin
                chk("req_ready_after_hs", 64'(req_ready), 64'd1);
                chk_idle = 1'b0;
            end
            resp_ready = 1'($urandom);
        end
    end

    initial begin
        bit          wr;
        bit          byt;
        int          r;
        int          acc;
        logic [63:0] a;

        // Reset held two cycles with a request pending: nothing may be accepted.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        reset     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", 64'(req_ready), 64'd1);
        chk("post_rst_busy", 64'(busy), 64'd0);

        for (int k = 0; k < 64; k += 8) do_req(1'b1, 1'b0, 64'(k), 64'd0);
        for (int k = DEPTH - 16; k < DEPTH; k += 8) do_req(1'b1, 1'b0, 64'(k), 64'd0);

        do_req(1'b1, 1'b0, 64'd16, 64'h0123_4567_89AB_CDEF);
        do_req(1'b0, 1'b0, 64'd16, 64'd0);
        do_req(1'b0, 1'b1, 64'd16, 64'd0);
        do_req(1'b1, 1'b1, 64'd17, 64'h5555_5555_5555_55AA);
        do_req(1'b0, 1'b0, 64'd16, 64'd0);
        do_req(1'b0, 1'b1, 64'd23, 64'd0);

        do_req(1'b0, 1'b0, 64'd20, 64'd0);
        do_req(1'b1, 1'b1, 64'(DEPTH), 64'h77);
        do_req(1'b1, 1'b0, 64'(DEPTH - 4), 64'h1122_3344_5566_7788);
        do_req(1'b1, 1'b1, 64'h0000_0001_0000_0010, 64'h99);
        do_req(1'b0, 1'b1, 64'(DEPTH - 1), 64'd0);
        do_req(1'b0, 1'b0, 64'(DEPTH - 8), 64'd0);
        do_req(1'b0, 1'b0, 64'd16, 64'd0);

        wait_drain();
        bp_stall = 5;
        do_req(1'b0, 1'b0, 64'd16, 64'd0);
        wait_drain();
        bp_stall = -1;

        // Reset arrives while the store is still waiting; the store must vanish.
        issue(1'b1, 1'b0, 64'd8, 64'hFFFF_FFFF_FFFF_FFFF, acc);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_wait_rst_busy", 64'(busy), 64'd0);
        chk("mid_wait_rst_resp_valid", 64'(resp_valid), 64'd0);
        do_req(1'b0, 1'b0, 64'd8, 64'd0);

        for (int k = 0; k < 150; k++) begin
            wr  = 1'($urandom);
            byt = 1'($urandom);
            r   = int'($urandom_range(0, 9));
            if (r < 6)       a = 64'($urandom_range(0, 63));
            else if (r < 8)  a = 64'(DEPTH - 16) + 64'($urandom_range(0, 15));
            else if (r == 8) a = 64'(DEPTH) + 64'($urandom_range(0, 15));
            else             a = {1'b1, $urandom, 31'($urandom)};
            if (!byt && $urandom_range(0, 3) != 0) a[2:0] = 3'b000;
            do_req(wr, byt, a, {$urandom, $urandom});
        end

        wait_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
